// File: rtl/piece_queue_if.sv
// piece_queue_if: handshake and status bundle for the next-piece queue.
//   slave  modport (queue side)     : takes random, spawn_req, hold_req;
//                                     drives spawn_*, preview, queue_count, hold_*.
//   master modport (controller side): the mirror image.
// DEPTH must match the DEPTH of the attached piece_queue (sets preview width).
interface piece_queue_if #(
  parameter int unsigned DEPTH = 3
);
  logic [1:0]         random;
  logic               spawn_req;
  logic               hold_req;
  logic               spawn_ack;
  logic [1:0]         spawn_type;
  logic [15:0]        spawn_shape;
  logic [3:0]         spawn_x;
  logic [2*DEPTH-1:0] preview;
  logic [2:0]         queue_count;
  logic               hold_valid;
  logic [1:0]         hold_type;

  modport master (
    output random, spawn_req, hold_req,
    input  spawn_ack, spawn_type, spawn_shape, spawn_x,
           preview, queue_count, hold_valid, hold_type
  );

  modport slave (
    input  random, spawn_req, hold_req,
    output spawn_ack, spawn_type, spawn_shape, spawn_x,
           preview, queue_count, hold_valid, hold_type
  );
endinterface

// File: rtl/piece_queue.sv
// piece_queue: next-piece preview FIFO, spawner and hold slot.
//   clka       - system clock, rising edge
//   restart_n  - asynchronous active-low reset
//   pq (slave) - random/spawn_req/hold_req in; spawn_ack pulse with
//                spawn_type/spawn_shape/spawn_x, preview, queue_count,
//                hold_valid/hold_type out.
// FILL samples the generator into the tail until DEPTH entries are held,
// READY serves one spawn (pop) or one hold action, then refills.
module piece_queue #(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned SPAWN_COL   = 3,
  parameter bit          ANTI_REPEAT = 1'b1
) (
  input  logic         clka,
  input  logic         restart_n,
  piece_queue_if.slave pq
);

  typedef enum logic {FILL, READY} state_t;

  state_t      state;
  logic [1:0]  q [DEPTH];
  logic [2:0]  count;
  logic [1:0]  last_type;
  logic [1:0]  cur_type;
  logic        cur_valid;
  logic        hold_used;
  logic        reroll;

  logic        spawn_ack_r;
  logic [1:0]  spawn_type_r;
  logic [15:0] spawn_shape_r;
  logic        hold_valid_r;
  logic [1:0]  hold_type_r;

  logic        dup_skip;
  logic        spawn_go;
  logic        hold_ok;
  logic        hold_first;
  logic        hold_swap;
  logic        pop;

  function automatic logic [15:0] shape_of(input logic [1:0] t);
    logic [15:0] s;
    case (t)
      2'd0:    s = 16'h0F00;
      2'd1:    s = 16'h6600;
      2'd2:    s = 16'hE400;
      default: s = 16'h2E00;
    endcase
    return s;
  endfunction

  // A duplicate of the last enqueued piece costs one skipped cycle, once;
  // the following cycle always enqueues whatever the generator shows.
  assign dup_skip   = ANTI_REPEAT && (pq.random == last_type) &&
                      (count != 3'd0) && !reroll;
  assign spawn_go   = (state == READY) && pq.spawn_req;
  assign hold_ok    = (state == READY) && !pq.spawn_req && pq.hold_req &&
                      cur_valid && !hold_used;
  assign hold_first = hold_ok && !hold_valid_r;
  assign hold_swap  = hold_ok && hold_valid_r;
  assign pop        = spawn_go || hold_first;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state         <= FILL;
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      count         <= '0;
      last_type     <= '0;
      cur_type      <= '0;
      cur_valid     <= 1'b0;
      hold_used     <= 1'b0;
      reroll        <= 1'b0;
      spawn_ack_r   <= 1'b0;
      spawn_type_r  <= '0;
      spawn_shape_r <= '0;
      hold_valid_r  <= 1'b0;
      hold_type_r   <= '0;
    end else begin
      spawn_ack_r <= 1'b0;
      case (state)
        FILL: begin
          if (dup_skip) begin
            reroll <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < DEPTH; i++)
              if (count == 3'(i)) q[i] <= pq.random;
            count     <= count + 3'd1;
            last_type <= pq.random;
            reroll    <= 1'b0;
            if (count + 3'd1 == 3'(DEPTH)) state <= READY;
          end
        end
        READY: begin
          if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) q[i] <= q[i+1];
            q[DEPTH-1]    <= '0;
            count         <= 3'(DEPTH - 1);
            spawn_ack_r   <= 1'b1;
            spawn_type_r  <= q[0];
            spawn_shape_r <= shape_of(q[0]);
            cur_type      <= q[0];
            cur_valid     <= 1'b1;
            state         <= FILL;
            // A hold that empties into the slot still spawns from the queue,
            // but the new piece must not be holdable again before a real spawn.
            if (hold_first) begin
              hold_type_r  <= cur_type;
              hold_valid_r <= 1'b1;
              hold_used    <= 1'b1;
            end else begin
              hold_used    <= 1'b0;
            end
          end else if (hold_swap) begin
            spawn_ack_r   <= 1'b1;
            spawn_type_r  <= hold_type_r;
            spawn_shape_r <= shape_of(hold_type_r);
            hold_type_r   <= cur_type;
            cur_type      <= hold_type_r;
            hold_used     <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Slots at or beyond count are forced to zero on the preview bus.
  always_comb begin
    pq.preview = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (3'(i) < count) pq.preview[2*i +: 2] = q[i];
  end

  assign pq.spawn_ack   = spawn_ack_r;
  assign pq.spawn_type  = spawn_type_r;
  assign pq.spawn_shape = spawn_shape_r;
  assign pq.spawn_x     = 4'(SPAWN_COL);
  assign pq.queue_count = count;
  assign pq.hold_valid  = hold_valid_r;
  assign pq.hold_type   = hold_type_r;

endmodule
